// File: rtl/cfu_vec_pkg.sv
// Shared CFU vector definitions: opcodes, issue-FSM states and index-width helper.
// Also consumed by decoder_block for its opcode decode.
package cfu_vec_pkg;

  localparam logic [4:0] OP_VSETVLI = 5'h17;
  localparam logic [4:0] OP_VLOAD   = 5'h07;
  localparam logic [4:0] OP_VADD    = 5'h15;
  localparam logic [4:0] OP_VACC    = 5'h0D;
  localparam logic [4:0] OP_VMUL    = 5'h04;
  localparam logic [4:0] OP_VBACC   = 5'h1D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DRAIN,
    S_RESP
  } cfu_state_e;

  function automatic int unsigned idxw(input int unsigned vlmax);
    return $clog2(vlmax + 1);
  endfunction

endpackage

// File: rtl/cfu_beat_counter.sv
// Loadable down-counter with an up-counting index and last-beat flag.
// Loading N yields N counts: idx runs 0..N-1 and last is high on the final one.
module cfu_beat_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
      idx <= '0;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
      idx <= idx + W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/cfu_cmd_issue.sv
// CFU command issue/sequencer: latches a command, replays it to the decoder as beats,
// drains the datapath and returns the response. Optional macro: CFU_ISSUE_ILLEGAL_TRAP_EN.
module cfu_cmd_issue
  import cfu_vec_pkg::*;
#(
  parameter int unsigned VLMAX    = 16,
  parameter int unsigned PIPE_LAT = 2,
  parameter int unsigned IDXW     = idxw(VLMAX)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [9:0]      cmd_payload_function_id,
  input  logic [31:0]     cmd_payload_inputs_0,
  input  logic [31:0]     cmd_payload_inputs_1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_payload_outputs_0,
  output logic            dec_valid,
  output logic [9:0]      dec_function_id,
  output logic [31:0]     dec_inputs_0,
  output logic [31:0]     dec_inputs_1,
  output logic [IDXW-1:0] dec_elem_idx,
  output logic [IDXW-1:0] vl,
  input  logic [31:0]     result_in
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  // One counter serves both the EXEC beats and the DRAIN wait, so size it for the larger.
  localparam int unsigned CNTMAX = (VLMAX > PIPE_LAT) ? VLMAX : PIPE_LAT;
  localparam int unsigned CNTW   = idxw(CNTMAX);

  cfu_state_e      state;
  logic            is_red;
  logic [4:0]      opcode;
  logic            op_red;
  logic [IDXW-1:0] new_vl;
  logic            cnt_load;
  logic [CNTW-1:0] cnt_val;
  logic            cnt_en;
  logic [CNTW-1:0] cnt_idx;
  logic            cnt_last;

  assign opcode = cmd_payload_function_id[9:5];
  assign op_red = (opcode == OP_VACC) || (opcode == OP_VBACC);
  assign new_vl = (cmd_payload_inputs_0 > 32'(VLMAX)) ? IDXW'(VLMAX)
                                                      : cmd_payload_inputs_0[IDXW-1:0];

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = CNTW'(1);
    cnt_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_load = cmd_valid;
        if (op_red) cnt_val = (vl == '0) ? CNTW'(PIPE_LAT) : CNTW'(vl);
      end
      S_EXEC: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          cnt_load = 1'b1;
          cnt_val  = CNTW'(PIPE_LAT);
        end
      end
      S_DRAIN: cnt_en = 1'b1;
      default: ;
    endcase
  end

  cfu_beat_counter #(.W(CNTW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .idx      (cnt_idx),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= S_IDLE;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      dec_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      dec_function_id       <= '0;
      dec_inputs_0          <= '0;
      dec_inputs_1          <= '0;
      dec_elem_idx          <= '0;
      vl                    <= '0;
      is_red                <= 1'b0;
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
      illegal               <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: if (cmd_valid) begin
          cmd_ready             <= 1'b0;
          dec_function_id       <= cmd_payload_function_id;
          dec_inputs_0          <= cmd_payload_inputs_0;
          dec_inputs_1          <= cmd_payload_inputs_1;
          dec_elem_idx          <= '0;
          rsp_payload_outputs_0 <= '0;
          is_red                <= op_red;
          case (opcode)
            OP_VSETVLI: begin
              vl                    <= new_vl;
              rsp_payload_outputs_0 <= 32'(new_vl);
              rsp_valid             <= 1'b1;
              state                 <= S_RESP;
            end
            OP_VACC, OP_VBACC: begin
              if (vl == '0) begin
                state <= S_DRAIN;
              end else begin
                dec_valid <= 1'b1;
                state     <= S_EXEC;
              end
            end
            OP_VLOAD, OP_VADD, OP_VMUL: begin
              dec_valid <= 1'b1;
              state     <= S_EXEC;
            end
            default: begin
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
              illegal               <= 1'b1;
              rsp_payload_outputs_0 <= '1;
              rsp_valid             <= 1'b1;
              state                 <= S_RESP;
`else
              dec_valid <= 1'b1;
              state     <= S_EXEC;
`endif
            end
          endcase
        end
        S_EXEC: begin
          if (cnt_last) begin
            dec_valid <= 1'b0;
            state     <= S_DRAIN;
          end else begin
            dec_elem_idx <= IDXW'(cnt_idx + CNTW'(1));
          end
        end
        S_DRAIN: if (cnt_last) begin
          if (is_red) rsp_payload_outputs_0 <= result_in;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_cmd_issue.sv
// Scoreboard bench for cfu_cmd_issue: directed commands push expected beats/responses,
// a negedge monitor pops and compares them. Honors CFU_ISSUE_ILLEGAL_TRAP_EN.
module tb_cfu_cmd_issue;

  localparam int unsigned VLMAX    = 16;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned IDXW     = $clog2(VLMAX + 1);
  localparam int          L1       = 1 + 1 + PIPE_LAT;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [9:0]      cmd_fid = '0;
  logic [31:0]     cmd_a = '0;
  logic [31:0]     cmd_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_data;
  logic            dec_valid;
  logic [9:0]      dec_fid;
  logic [31:0]     dec_a;
  logic [31:0]     dec_b;
  logic [IDXW-1:0] dec_idx;
  logic [IDXW-1:0] vl;
  logic [31:0]     result_in;
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  typedef struct {
    logic [9:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
    int          idx;
    int          cyc;
  } beat_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  beat_t       mb;
  rsp_t        mr;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          res_cyc = -1;
  logic [31:0] res_val = '0;
  logic        prev_rv = 1'b0;

  cfu_cmd_issue #(.VLMAX(VLMAX), .PIPE_LAT(PIPE_LAT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_fid),
    .cmd_payload_inputs_0    (cmd_a),
    .cmd_payload_inputs_1    (cmd_b),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data),
    .dec_valid               (dec_valid),
    .dec_function_id         (dec_fid),
    .dec_inputs_0            (dec_a),
    .dec_inputs_1            (dec_b),
    .dec_elem_idx            (dec_idx),
    .vl                      (vl),
    .result_in               (result_in)
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
    ,
    .illegal                 (illegal)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath result is only meaningful on the last drain cycle; garbage elsewhere.
  assign result_in = (cyc == res_cyc) ? res_val : (32'hBAD0_0000 ^ 32'(cyc));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                             input int nb, input int lat, input logic [31:0] rdata,
                             input bit red, input int acc);
    for (int i = 0; i < nb; i++) beat_q.push_back('{fid, a, b, i, acc + 1 + i});
    rsp_q.push_back('{rdata, acc + lat});
    if (red) begin
      res_cyc = acc + lat - 1;
      res_val = rdata;
    end
  endtask

  task automatic issue(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                       input int nb, input int lat, input logic [31:0] rdata, input bit red);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_fid   = fid;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      fail_now("accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    push_expect(fid, a, b, nb, lat, rdata, red, cyc);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((beat_q.size() != 0 || rsp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (beat_q.size() != 0 || rsp_q.size() != 0) begin
      fail_now("drain_timeout");
      beat_q.delete();
      rsp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    beat_q.delete();
    rsp_q.delete();
    res_cyc = -1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (dec_valid) begin
        if (beat_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          mb = beat_q.pop_front();
          check("beat_cycle", 32'(cyc), 32'(mb.cyc));
          check("beat_fid", 32'(dec_fid), 32'(mb.fid));
          check("beat_in0", dec_a, mb.a);
          check("beat_in1", dec_b, mb.b);
          check("beat_idx", 32'(dec_idx), 32'(mb.idx));
        end
      end
      if (rsp_valid && !prev_rv) begin
        if (rsp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          check("rsp_cycle", 32'(cyc), 32'(rsp_q[0].cyc));
          check("rsp_data_rise", rsp_data, rsp_q[0].data);
        end
      end
      if (rsp_valid && rsp_ready && rsp_q.size() != 0) begin
        mr = rsp_q.pop_front();
        check("rsp_data", rsp_data, mr.data);
      end
    end
    prev_rv = rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_dec_fid", 32'(dec_fid), 32'd0);
    check("rst_dec_in0", dec_a, 32'd0);
    check("rst_dec_in1", dec_b, 32'd0);
    check("rst_dec_idx", 32'(dec_idx), 32'd0);
    check("rst_vl", 32'(vl), 32'd0);
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
    check("rst_illegal", 32'(illegal), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // vsetvli: plain, saturating, large unsigned, zero
    issue({5'h17, 5'd1}, 32'd8, 32'd0, 0, 1, 32'd8, 1'b0);
    wait_done();
    check("vl_8", 32'(vl), 32'd8);
    issue({5'h17, 5'd1}, 32'd100, 32'd0, 0, 1, 32'd16, 1'b0);
    wait_done();
    check("vl_100", 32'(vl), 32'd16);
    issue({5'h17, 5'd2}, 32'hFFFF_FFF0, 32'd0, 0, 1, 32'd16, 1'b0);
    wait_done();
    issue({5'h17, 5'd2}, 32'd17, 32'd0, 0, 1, 32'd16, 1'b0);
    wait_done();
    issue({5'h17, 5'd2}, 32'd0, 32'd0, 0, 1, 32'd0, 1'b0);
    wait_done();
    check("vl_0", 32'(vl), 32'd0);
    issue({5'h0D, 5'd6}, 32'h1, 32'h2, 0, 3, 32'h0000_7777, 1'b1);
    wait_done();

    // single-beat ops, back to back
    issue({5'h15, 5'd3}, 32'h11, 32'h22, 1, L1, 32'd0, 1'b0);
    issue({5'h04, 5'd4}, 32'h33, 32'h44, 1, L1, 32'd0, 1'b0);
    wait_done();
    issue({5'h07, 5'd5}, 32'h1000, 32'h0, 1, L1, 32'd0, 1'b0);
    wait_done();

    // reductions
    issue({5'h17, 5'd1}, 32'd5, 32'd0, 0, 1, 32'd5, 1'b0);
    wait_done();
    issue({5'h0D, 5'd4}, 32'hA, 32'hB, 5, 1 + 5 + PIPE_LAT, 32'h0000_1234, 1'b1);
    wait_done();
    issue({5'h17, 5'd1}, 32'd16, 32'd0, 0, 1, 32'd16, 1'b0);
    wait_done();
    issue({5'h1D, 5'd7}, 32'hC, 32'hD, 16, 1 + 16 + PIPE_LAT, 32'hCAFE_F00D, 1'b1);
    wait_done();

    // response backpressure with a command waiting
    issue({5'h17, 5'd1}, 32'd2, 32'd0, 0, 1, 32'd2, 1'b0);
    wait_done();
    rsp_ready = 1'b0;
    issue({5'h0D, 5'd8}, 32'h5, 32'h6, 2, 1 + 2 + PIPE_LAT, 32'h0BEE_F001, 1'b1);
    cmd_valid = 1'b1;
    cmd_fid   = {5'h07, 5'd1};
    cmd_a     = 32'h40;
    cmd_b     = 32'h0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) fail_now("stall_rsp_timeout");
    for (int i = 0; i < 10; i++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", rsp_data, 32'h0BEE_F001);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    check("hs_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    push_expect(cmd_fid, cmd_a, cmd_b, 1, L1, 32'd0, 1'b0, cyc);
    tick();
    cmd_valid = 1'b0;
    wait_done();

    // unknown opcode
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
    issue({5'h1F, 5'd9}, 32'h1, 32'h2, 0, 1, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    check("illegal_set", 32'(illegal), 32'd1);
    issue({5'h15, 5'd3}, 32'h1, 32'h2, 1, L1, 32'd0, 1'b0);
    wait_done();
    check("illegal_sticky", 32'(illegal), 32'd1);
`else
    issue({5'h1F, 5'd9}, 32'h1, 32'h2, 1, L1, 32'd0, 1'b0);
    wait_done();
`endif

    // reset during reduction beats
    issue({5'h17, 5'd1}, 32'd5, 32'd0, 0, 1, 32'd5, 1'b0);
    wait_done();
    issue({5'h0D, 5'd4}, 32'h3, 32'h4, 5, 1 + 5 + PIPE_LAT, 32'h0000_9999, 1'b1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    #1;
    beat_q.delete();
    rsp_q.delete();
    res_cyc = -1;
    tick();
    check("abort_dec_valid", 32'(dec_valid), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_vl", 32'(vl), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef CFU_ISSUE_ILLEGAL_TRAP_EN
    check("abort_illegal", 32'(illegal), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // reduction with vl=0 after reset: no beats, response at cycle 3
    pulse_reset();
    tick();
    issue({5'h1D, 5'd2}, 32'h7, 32'h8, 0, 3, 32'h0000_5A5A, 1'b1);
    wait_done();

    tick();
    tick();
    check("end_beat_q_empty", 32'(beat_q.size()), 32'd0);
    check("end_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
